// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encodings and requester IDs.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_arbiter_bus_timeout_ctr.sv
// Bus watchdog: counts busy cycles without an ack and flags the cycle in which
// the TIMEOUT-th unacknowledged cycle completes. TIMEOUT=0 disables the watchdog.
module bus_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] MAX_COUNT  = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST_COUNT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] count_reg;

    // Saturating cycle counter, restarted at each grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != MAX_COUNT)) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    // Expiry fires while the final allowed cycle is still in progress so the
    // request is dropped after exactly TIMEOUT cycles
    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            assign expired = enable && (count_reg == LAST_COUNT);
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory between instruction
// fetch and load/store ports, with a bus-timeout watchdog and a PC stall output.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_done,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_done,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata,
    output logic            bus_err,
    output logic            stall
);

    arb_state_t state_reg, state_next;
    gnt_t       last_gnt_reg, last_gnt_next;
    logic       grant_if, grant_d;
    logic       busy, ack, expired;

    assign busy  = (state_reg != IDLE);
    assign ack   = busy && mem_ack;
    assign stall = (if_req && !if_done) || (d_req && !d_done);

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (grant_if || grant_d),
        .enable  (busy && !mem_ack),
        .expired (expired)
    );

    // Next-state and grant decision; grants happen only from IDLE
    always_comb begin
        state_next    = state_reg;
        last_gnt_next = last_gnt_reg;
        grant_if      = 1'b0;
        grant_d       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (if_req && d_req) begin
                    grant_d  = (last_gnt_reg == GNT_IF);
                    grant_if = (last_gnt_reg == GNT_D);
                end else begin
                    grant_if = if_req;
                    grant_d  = d_req;
                end
                if (grant_if) begin
                    state_next    = BUSY_I;
                    last_gnt_next = GNT_IF;
                end else if (grant_d) begin
                    state_next    = BUSY_D;
                    last_gnt_next = GNT_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (ack || expired) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state and round-robin history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            last_gnt_reg <= GNT_IF;
        end else begin
            state_reg    <= state_next;
            last_gnt_reg <= last_gnt_next;
        end
    end

    // Registered memory-side request fields, read data and completion pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            if_rdata  <= '0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            bus_err   <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            bus_err <= 1'b0;
            if (grant_if) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_be    <= '1;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end else if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_be    <= d_be;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (ack || expired) begin
                // Ack takes priority over a coincident timeout
                mem_req <= 1'b0;
                bus_err <= !ack;
                if (state_reg == BUSY_I) begin
                    if_done  <= 1'b1;
                    if_rdata <= ack ? mem_rdata : '0;
                end else begin
                    d_done  <= 1'b1;
                    d_rdata <= (ack && !mem_we) ? mem_rdata : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT=8). Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        bus_err;
    logic        stall;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_if_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err),
        .stall     (stall)
    );

    task automatic test_reset();
        reset = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, if_done, d_done, bus_err, stall} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000", {mem_req, if_done, d_done, bus_err, stall});
        end
        checks++;
        if ({mem_addr, if_rdata, d_rdata} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {mem_addr, if_rdata, d_rdata});
        end
        reset = 1'b1;
        // start a load, then reset in the middle of BUSY_D
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h10;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_busy: mem_req got %b expected 1", mem_req);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_drop: mem_req got %b expected 0", mem_req);
        end
        d_req = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({mem_req, if_done, d_done, bus_err} !== 4'b0) begin
                errors++;
                $display("FAIL reset_no_done: got %b expected 0000", {mem_req, if_done, d_done, bus_err});
            end
        end
        $display("txn reset mid-busy done");
    endtask

    task automatic test_fetch();
        int pulses;
        @(negedge clk);
        if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_be} !== 6'b1_0_1111) begin
            errors++;
            $display("FAIL fetch_req: req/we/be got %b expected 101111", {mem_req, mem_we, mem_be});
        end
        checks++;
        if (mem_addr !== 32'h100 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL fetch_addr: addr/wdata got %h/%h expected 100/0", mem_addr, mem_wdata);
        end
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1; mem_rdata = 32'h00500093;
        @(negedge clk);
        mem_ack = 0; mem_rdata = 32'h0;
        checks++;
        if (if_done !== 1'b1 || if_rdata !== 32'h00500093) begin
            errors++;
            $display("FAIL fetch_done: done/rdata got %b/%h expected 1/00500093", if_done, if_rdata);
        end
        checks++;
        if (mem_req !== 1'b0 || d_done !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL fetch_side: req/d_done/err got %b%b%b expected 000", mem_req, d_done, bus_err);
        end
        if_req = 0;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (if_done) pulses++;
        end
        checks++;
        if (pulses !== 0 || if_rdata !== 32'h00500093) begin
            errors++;
            $display("FAIL fetch_once: extra pulses %0d rdata %h expected 0/00500093", pulses, if_rdata);
        end
        $display("txn fetch addr=00000100 rdata=%h", if_rdata);
    endtask

    task automatic test_stall();
        @(negedge clk);
        if_req = 1; if_addr = 32'h104;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_req_cycle: got %b expected 1", stall);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 2) begin
                mem_ack = 1; mem_rdata = 32'h00A00113;
            end
            checks++;
            if (stall !== 1'b1 || mem_req !== 1'b1) begin
                errors++;
                $display("FAIL stall_busy: stall/req got %b%b expected 11", stall, mem_req);
            end
        end
        @(negedge clk);
        mem_ack = 0;
        checks++;
        if (stall !== 1'b0 || if_done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done_cycle: stall/done got %b%b expected 01", stall, if_done);
        end
        if_req = 0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_after: got %b expected 0", stall);
        end
        $display("txn stall fetch addr=00000104 rdata=%h", if_rdata);
    endtask

    task automatic test_store();
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h2004; d_be = 4'b0011; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_be} !== 6'b1_1_0011) begin
            errors++;
            $display("FAIL store_req: req/we/be got %b expected 110011", {mem_req, mem_we, mem_be});
        end
        checks++;
        if (mem_addr !== 32'h2004 || mem_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_fields: addr/wdata got %h/%h expected 2004/deadbeef", mem_addr, mem_wdata);
        end
        mem_ack = 1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_ack = 0; mem_rdata = 0;
        checks++;
        if (d_done !== 1'b1 || d_rdata !== 32'h0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL store_done: done/rdata/err got %b/%h/%b expected 1/0/0", d_done, d_rdata, bus_err);
        end
        checks++;
        if (mem_req !== 1'b0 || if_done !== 1'b0) begin
            errors++;
            $display("FAIL store_side: req/if_done got %b%b expected 00", mem_req, if_done);
        end
        d_req = 0; d_we = 0;
        @(negedge clk);
        checks++;
        if (d_done !== 1'b0) begin
            errors++;
            $display("FAIL store_pulse: d_done got %b expected 0", d_done);
        end
        $display("txn store addr=00002004 be=0011 wdata=deadbeef");
    endtask

    task automatic test_contention();
        logic        exp_d;
        logic [31:0] exp_addr;
        logic [31:0] rd;
        int          n_if;
        int          n_d;
        n_if = 0; n_d = 0;
        @(negedge clk);
        reset = 1'b0;
        if_req = 1; if_addr = 32'h40;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h80;
        @(negedge clk);
        reset = 1'b1;
        exp_d = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            exp_addr = exp_d ? 32'h80 : 32'h40;
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
                errors++;
                $display("FAIL contention_grant %0d: req/addr got %b/%h expected 1/%h", t, mem_req, mem_addr, exp_addr);
            end
            rd = 32'hA0000000 | t;
            mem_ack = 1; mem_rdata = rd;
            @(negedge clk);
            mem_ack = 0; mem_rdata = 0;
            if (if_done) n_if++;
            if (d_done) n_d++;
            checks++;
            if ({if_done, d_done} !== {~exp_d, exp_d}) begin
                errors++;
                $display("FAIL contention_done %0d: if/d got %b%b expected %b%b", t, if_done, d_done, ~exp_d, exp_d);
            end
            checks++;
            if ((exp_d ? d_rdata : if_rdata) !== rd) begin
                errors++;
                $display("FAIL contention_rdata %0d: got %h expected %h", t, exp_d ? d_rdata : if_rdata, rd);
            end
            checks++;
            if (mem_req !== 1'b0 || bus_err !== 1'b0) begin
                errors++;
                $display("FAIL contention_idle %0d: req/err got %b%b expected 00", t, mem_req, bus_err);
            end
            $display("txn contention %0d port=%s rdata=%h", t, exp_d ? "D" : "IF", rd);
            if (!exp_d) exp_if_rdata = rd;
            exp_d = ~exp_d;
            if (t == 19) begin
                if_req = 0; d_req = 0;
            end
        end
        checks++;
        if (n_if !== 10 || n_d !== 10) begin
            errors++;
            $display("FAIL contention_fair: if/d got %0d/%0d expected 10/10", n_if, n_d);
        end
    endtask

    task automatic test_timeout();
        int cnt;
        bit seen;
        for (int phase = 0; phase < 2; phase++) begin
            @(negedge clk);
            d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h300 + phase;
            cnt = 0; seen = 0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                mem_ack = 0; mem_rdata = 0;
                if (d_done) begin
                    seen = 1;
                    checks++;
                    if (cnt !== 8) begin
                        errors++;
                        $display("FAIL timeout_len phase%0d: mem_req cycles got %0d expected 8", phase, cnt);
                    end
                    checks++;
                    if (bus_err !== (phase == 0)) begin
                        errors++;
                        $display("FAIL timeout_err phase%0d: bus_err got %b expected %b", phase, bus_err, phase == 0);
                    end
                    checks++;
                    if (d_rdata !== ((phase == 0) ? 32'h0 : 32'hCAFEF00D) || mem_req !== 1'b0) begin
                        errors++;
                        $display("FAIL timeout_rdata phase%0d: rdata/req got %h/%b", phase, d_rdata, mem_req);
                    end
                    d_req = 0;
                end else if (mem_req) begin
                    cnt++;
                    if (phase == 1 && cnt == 8) begin
                        mem_ack = 1; mem_rdata = 32'hCAFEF00D;
                    end
                end
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL timeout_done phase%0d: no d_done within 20 cycles", phase);
            end
            d_req = 0;
            @(negedge clk);
            checks++;
            if (bus_err !== 1'b0 || d_done !== 1'b0) begin
                errors++;
                $display("FAIL timeout_pulse phase%0d: err/done got %b%b expected 00", phase, bus_err, d_done);
            end
            $display("txn timeout phase%0d cycles=%0d rdata=%h", phase, cnt, d_rdata);
        end
    endtask

    task automatic test_ack_ignored();
        @(negedge clk);
        mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        mem_ack = 0; mem_rdata = 0;
        checks++;
        if ({mem_req, if_done, d_done, bus_err} !== 4'b0) begin
            errors++;
            $display("FAIL stray_ack: got %b expected 0000", {mem_req, if_done, d_done, bus_err});
        end
        checks++;
        if (if_rdata !== exp_if_rdata) begin
            errors++;
            $display("FAIL stray_ack_hold: if_rdata got %h expected %h", if_rdata, exp_if_rdata);
        end
        $display("txn stray ack ignored");
    endtask

    initial begin
        exp_if_rdata = 32'h0;
        test_reset();
        test_fetch();
        test_stall();
        test_store();
        test_contention();
        test_timeout();
        test_ack_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
